ddr3_fifo_bridge: RTL and testbench

- Memory-side drain/fill engine sitting between the cache request FIFOs and a MIG-style DDR3 application interface.
- Pops write-back lines (address + 128-bit data) from the write FIFO and issues DDR3 writes.
- Pops line-fill addresses from the read-in FIFO, issues DDR3 reads, and pushes the returned 128-bit line into the read-out FIFO.
- One transaction in flight at a time; writes have strict priority over reads so a write-back always reaches DDR3 before any later fill.

---
 rtl/ddr3_fifo_bridge_if.sv | 68 ++++++
 rtl/ddr3_fifo_bridge.sv | 205 ++++++++++++++++++++
 tb/tb_ddr3_fifo_bridge.sv | 406 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ddr3_fifo_bridge_if.sv
// ddr3_fifo_bridge_if
//
// Purpose:
//   Bundles every handshake and data signal between the cache-side request
//   FIFOs, the bridge, and a MIG-style DDR3 application interface.
//
// Modports:
//   master - the bridge. It pops the write FIFO and the read-in FIFO, pushes
//            the read-out FIFO, and drives DDR3 commands and write data.
//   slave  - the environment: FIFOs plus the DDR3 controller.
//
// Signal groups:
//   wr_fifo_*      write-back FIFO (FWFT): empty, addr, data in; rd_en out
//   rd_req_fifo_*  line-fill request FIFO (FWFT): empty, addr in; rd_en out
//   rd_resp_fifo_* line-fill response FIFO: full in; wr_en, data out
//   app_*          DDR3 command, write-data and read-data channels
interface ddr3_fifo_bridge_if #(
    parameter int ADDR_WIDTH = 28
);
    logic                  wr_fifo_empty;
    logic [31:0]           wr_fifo_addr;
    logic [127:0]          wr_fifo_data;
    logic                  wr_fifo_rd_en;

    logic                  rd_req_fifo_empty;
    logic [31:0]           rd_req_fifo_addr;
    logic                  rd_req_fifo_rd_en;

    logic                  rd_resp_fifo_full;
    logic                  rd_resp_fifo_wr_en;
    logic [127:0]          rd_resp_fifo_data;

    logic [ADDR_WIDTH-1:0] app_addr;
    logic [2:0]            app_cmd;
    logic                  app_en;
    logic                  app_rdy;
    logic [127:0]          app_wdf_data;
    logic [15:0]           app_wdf_mask;
    logic                  app_wdf_wren;
    logic                  app_wdf_end;
    logic                  app_wdf_rdy;
    logic [127:0]          app_rd_data;
    logic                  app_rd_data_valid;

    modport master (
        input  wr_fifo_empty, wr_fifo_addr, wr_fifo_data,
        output wr_fifo_rd_en,
        input  rd_req_fifo_empty, rd_req_fifo_addr,
        output rd_req_fifo_rd_en,
        input  rd_resp_fifo_full,
        output rd_resp_fifo_wr_en, rd_resp_fifo_data,
        output app_addr, app_cmd, app_en, app_wdf_data, app_wdf_mask,
        output app_wdf_wren, app_wdf_end,
        input  app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid
    );

    modport slave (
        output wr_fifo_empty, wr_fifo_addr, wr_fifo_data,
        input  wr_fifo_rd_en,
        output rd_req_fifo_empty, rd_req_fifo_addr,
        input  rd_req_fifo_rd_en,
        output rd_resp_fifo_full,
        input  rd_resp_fifo_wr_en, rd_resp_fifo_data,
        input  app_addr, app_cmd, app_en, app_wdf_data, app_wdf_mask,
        input  app_wdf_wren, app_wdf_end,
        output app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid
    );
endinterface

// File: rtl/ddr3_fifo_bridge.sv
// ddr3_fifo_bridge
//
// Purpose:
//   Memory-side engine between the cache request FIFOs and a DDR3 application
//   interface. Write-backs are popped from the write FIFO and issued as DDR3
//   writes. Fill addresses are popped from the read-in FIFO and issued as
//   DDR3 reads, and the returned line is pushed into the read-out FIFO. Only
//   one transaction is in flight at a time. Writes always win over reads, so a
//   write-back reaches DDR3 before any later fill of the same line.
//
// Ports:
//   clk                 clock
//   reset               synchronous, active-high reset
//   init_calib_complete DDR3 calibrated; new pops are blocked while low
//   bus                 ddr3_fifo_bridge_if.master (FIFO and DDR3 app signals)
//   busy                high whenever a transaction is in progress
//   timeout_err         sticky read-response watchdog flag
//
// Optional feature (macro DDR3_BRIDGE_TIMEOUT_EN):
//   When the macro is defined, a watchdog counts cycles spent waiting for read
//   data. After TIMEOUT_CYCLES cycles with no response, the line
//   {4{32'hDEADBEEF}} is pushed instead and timeout_err is set until reset.
//   When the macro is undefined, the bridge waits indefinitely and
//   timeout_err is tied low.
module ddr3_fifo_bridge #(
    parameter int ADDR_WIDTH     = 28,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                init_calib_complete,
    ddr3_fifo_bridge_if.master  bus,
    output logic                busy,
    output logic                timeout_err
);

    typedef enum logic [2:0] {
        IDLE,
        WR_CMD,
        RD_CMD,
        RD_WAIT,
        RD_PUSH
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] lineAddr_q, lineAddr_d;
    logic                  cmdRead_q, cmdRead_d;
    logic [127:0]          wrData_q, wrData_d;
    logic [127:0]          rdData_q, rdData_d;
    logic                  cmdDone_q, cmdDone_d;
    logic                  dataDone_q, dataDone_d;

    // The FIFO addresses are byte addresses. Only the line-aligned part that
    // fits in the DDR3 address is used.
    logic unusedAddrBits;
    assign unusedAddrBits = ^{bus.wr_fifo_addr, bus.rd_req_fifo_addr};

`ifdef DDR3_BRIDGE_TIMEOUT_EN
    localparam int CntW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CntW-1:0] waitCnt_q, waitCnt_d;
    logic            timeoutErr_q, timeoutErr_d;
    assign timeout_err = timeoutErr_q;
`else
    localparam int unusedTimeoutCycles = TIMEOUT_CYCLES;
    assign timeout_err = 1'b0;
`endif

    // The command and data channels are driven straight from the latched
    // transaction. app_wdf_end mirrors wren because every line is one beat.
    assign bus.app_addr          = lineAddr_q;
    assign bus.app_cmd           = {2'b00, cmdRead_q};
    assign bus.app_wdf_data      = wrData_q;
    assign bus.app_wdf_mask      = 16'h0000;
    assign bus.app_wdf_end       = bus.app_wdf_wren;
    assign bus.rd_resp_fifo_data = rdData_q;
    assign busy                  = (state_q != IDLE);

    // Next-state and strobe logic.
    // In WR_CMD the command half and the data half each drop on their own
    // acceptance, and the state leaves only when both halves are done. All
    // strobes are forced low during reset so that no FIFO entry is popped and
    // then lost by the reset itself.
    always_comb begin
        state_d                = state_q;
        lineAddr_d             = lineAddr_q;
        cmdRead_d              = cmdRead_q;
        wrData_d               = wrData_q;
        rdData_d               = rdData_q;
        cmdDone_d              = cmdDone_q;
        dataDone_d             = dataDone_q;
        bus.wr_fifo_rd_en      = 1'b0;
        bus.rd_req_fifo_rd_en  = 1'b0;
        bus.rd_resp_fifo_wr_en = 1'b0;
        bus.app_en             = 1'b0;
        bus.app_wdf_wren       = 1'b0;
`ifdef DDR3_BRIDGE_TIMEOUT_EN
        waitCnt_d              = waitCnt_q;
        timeoutErr_d           = timeoutErr_q;
`endif

        case (state_q)
            IDLE: begin
                if (init_calib_complete && !bus.wr_fifo_empty) begin
                    bus.wr_fifo_rd_en = 1'b1;
                    lineAddr_d        = {bus.wr_fifo_addr[ADDR_WIDTH-1:4], 4'b0000};
                    wrData_d          = bus.wr_fifo_data;
                    cmdRead_d         = 1'b0;
                    cmdDone_d         = 1'b0;
                    dataDone_d        = 1'b0;
                    state_d           = WR_CMD;
                end else if (init_calib_complete && !bus.rd_req_fifo_empty) begin
                    bus.rd_req_fifo_rd_en = 1'b1;
                    lineAddr_d            = {bus.rd_req_fifo_addr[ADDR_WIDTH-1:4], 4'b0000};
                    cmdRead_d             = 1'b1;
                    state_d               = RD_CMD;
                end
            end
            WR_CMD: begin
                bus.app_en       = !cmdDone_q;
                bus.app_wdf_wren = !dataDone_q;
                cmdDone_d        = cmdDone_q | bus.app_rdy;
                dataDone_d       = dataDone_q | bus.app_wdf_rdy;
                if (cmdDone_d && dataDone_d) begin
                    state_d = IDLE;
                end
            end
            RD_CMD: begin
                bus.app_en = 1'b1;
                if (bus.app_rdy) begin
                    state_d = RD_WAIT;
`ifdef DDR3_BRIDGE_TIMEOUT_EN
                    waitCnt_d = '0;
`endif
                end
            end
            RD_WAIT: begin
                if (bus.app_rd_data_valid) begin
                    rdData_d = bus.app_rd_data;
                    state_d  = RD_PUSH;
                end
`ifdef DDR3_BRIDGE_TIMEOUT_EN
                else if (waitCnt_q == CntW'(TIMEOUT_CYCLES - 1)) begin
                    rdData_d     = {4{32'hDEAD_BEEF}};
                    timeoutErr_d = 1'b1;
                    state_d      = RD_PUSH;
                end else begin
                    waitCnt_d = waitCnt_q + 1'b1;
                end
`endif
            end
            RD_PUSH: begin
                if (!bus.rd_resp_fifo_full) begin
                    bus.rd_resp_fifo_wr_en = 1'b1;
                    state_d                = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (reset) begin
            bus.wr_fifo_rd_en      = 1'b0;
            bus.rd_req_fifo_rd_en  = 1'b0;
            bus.rd_resp_fifo_wr_en = 1'b0;
            bus.app_en             = 1'b0;
            bus.app_wdf_wren       = 1'b0;
        end
    end

    // State and transaction registers. Reset discards any latched transaction.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            lineAddr_q <= '0;
            cmdRead_q  <= 1'b0;
            wrData_q   <= '0;
            rdData_q   <= '0;
            cmdDone_q  <= 1'b0;
            dataDone_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            lineAddr_q <= lineAddr_d;
            cmdRead_q  <= cmdRead_d;
            wrData_q   <= wrData_d;
            rdData_q   <= rdData_d;
            cmdDone_q  <= cmdDone_d;
            dataDone_q <= dataDone_d;
        end
    end

`ifdef DDR3_BRIDGE_TIMEOUT_EN
    // Watchdog counter and the sticky error flag. Only reset clears the flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            waitCnt_q    <= '0;
            timeoutErr_q <= 1'b0;
        end else begin
            waitCnt_q    <= waitCnt_d;
            timeoutErr_q <= timeoutErr_d;
        end
    end
`endif

endmodule

// File: tb/tb_ddr3_fifo_bridge.sv
// tb_ddr3_fifo_bridge
//
// Purpose:
//   Self-checking bench for ddr3_fifo_bridge. The write FIFO and the read-in
//   FIFO are modelled as queues, and DDR3 is modelled as a sparse line memory.
//   Each FIFO pop is put into an ordered expectation list. DDR3 writes update
//   the memory. Every pushed fill line must equal the memory content of its
//   line at the moment the read was accepted.
//
// Ports: none (top-level bench).
// Optional feature: the timeout scenario is built only when
//   DDR3_BRIDGE_TIMEOUT_EN is defined. Otherwise timeout_err must stay 0.
module tb_ddr3_fifo_bridge;

    localparam int AW  = 28;
    localparam int TMO = 16;

    typedef struct {
        logic [31:0]  addr;
        logic [127:0] data;
    } wrEntry_t;

    logic clk = 1'b0;
    logic reset;
    logic calib;
    logic busy;
    logic timeoutErr;

    ddr3_fifo_bridge_if #(.ADDR_WIDTH(AW)) bus ();

    ddr3_fifo_bridge #(
        .ADDR_WIDTH     (AW),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk                 (clk),
        .reset               (reset),
        .init_calib_complete (calib),
        .bus                 (bus),
        .busy                (busy),
        .timeout_err         (timeoutErr)
    );

    // Free-running 100 MHz clock.
    always #5 clk = ~clk;

    wrEntry_t     wrQ[$];
    logic [31:0]  rdQ[$];
    wrEntry_t     expWr[$];
    logic [31:0]  expRd[$];
    logic [127:0] expResp[$];
    logic [127:0] mem [logic [AW-1:0]];

    int testsRun = 0;
    int testsFailed = 0;
    int rdyPct = 100;
    int wdfPct = 100;
    int fullPct = 0;
    int latFixed = 0;
    bit respEnable = 1'b1;
    bit forceFull = 1'b0;
    bit injectValid = 1'b0;
    int wrPops = 0;
    int rdPops = 0;
    int ddrWrites = 0;
    int ddrReads = 0;
    int pushes = 0;
    int cycle = 0;
    int rdAcceptCycle = 0;
    int pushCycle = 0;
    int respCnt = 0;
    logic [127:0] lastPush = '0;
    logic [127:0] respData = '0;
    bit haveCmd = 1'b0;
    bit haveData = 1'b0;
    logic [AW-1:0] pendAddr = '0;
    logic [127:0] pendData = '0;

    // Counts one comparison and reports it when the observed value differs.
    task automatic checkOutput(input string tag, input logic [127:0] observed,
                               input logic [127:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    function automatic logic [AW-1:0] lineAddr(input logic [31:0] a);
        return {a[AW-1:4], 4'b0000};
    endfunction

    function automatic logic [127:0] memRead(input logic [AW-1:0] a);
        if (mem.exists(a)) return mem[a];
        return {4{{4'h0, a}}} ^ 128'h5A5A_5A5A_0F0F_0F0F_A5A5_A5A5_F0F0_F0F0;
    endfunction

    function automatic logic [127:0] randData();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Drives the FIFO heads and the DDR3 handshake inputs for the coming cycle.
    task automatic applyStimulus();
        bus.wr_fifo_empty     = (wrQ.size() == 0);
        bus.wr_fifo_addr      = (wrQ.size() != 0) ? wrQ[0].addr : $urandom;
        bus.wr_fifo_data      = (wrQ.size() != 0) ? wrQ[0].data : randData();
        bus.rd_req_fifo_empty = (rdQ.size() == 0);
        bus.rd_req_fifo_addr  = (rdQ.size() != 0) ? rdQ[0] : $urandom;
        bus.app_rdy           = (int'($urandom_range(99)) < rdyPct);
        bus.app_wdf_rdy       = (int'($urandom_range(99)) < wdfPct);
        bus.rd_resp_fifo_full = forceFull || (int'($urandom_range(99)) < fullPct);
        bus.app_rd_data_valid = 1'b0;
        bus.app_rd_data       = randData();
        if (injectValid) begin
            bus.app_rd_data_valid = 1'b1;
            injectValid = 1'b0;
        end else if (respCnt > 0) begin
            respCnt--;
            if (respCnt == 0) begin
                bus.app_rd_data_valid = 1'b1;
                bus.app_rd_data       = respData;
            end
        end
    endtask

    // Observes the handshakes that complete at the next rising edge and
    // updates the reference model.
    task automatic observeCycle();
        bit wrEmptyBefore;
        wrEntry_t e;
        logic [31:0] a;
        cycle++;
        wrEmptyBefore = (wrQ.size() == 0);
        if (bus.wr_fifo_rd_en) begin
            checkOutput("wrPopCalib", calib, 1'b1);
            checkOutput("wrPopNonEmpty", !wrEmptyBefore, 1'b1);
            if (!wrEmptyBefore) expWr.push_back(wrQ.pop_front());
            wrPops++;
        end
        if (bus.rd_req_fifo_rd_en) begin
            checkOutput("rdPopCalib", calib, 1'b1);
            checkOutput("rdPopPriority", wrEmptyBefore && !bus.wr_fifo_rd_en, 1'b1);
            if (rdQ.size() != 0) expRd.push_back(rdQ.pop_front());
            rdPops++;
        end
        if (bus.app_en && bus.app_rdy) begin
            if (bus.app_cmd == 3'b000) begin
                haveCmd  = 1'b1;
                pendAddr = bus.app_addr;
            end else if (bus.app_cmd == 3'b001) begin
                checkOutput("rdAfterWrites", expWr.size() == 0 && !haveCmd && !haveData, 1'b1);
                if (expRd.size() != 0) begin
                    a = expRd.pop_front();
                    checkOutput("rdCmdAddr", bus.app_addr, lineAddr(a));
                end else begin
                    checkOutput("unexpectedRead", 1'b1, 1'b0);
                end
                respData = memRead(bus.app_addr);
                expResp.push_back(respData);
                rdAcceptCycle = cycle;
                if (respEnable) respCnt = (latFixed > 0) ? latFixed : int'($urandom_range(1, 8));
                ddrReads++;
            end else begin
                checkOutput("appCmd", bus.app_cmd, 3'b000);
            end
        end
        if (bus.app_wdf_wren && bus.app_wdf_rdy) begin
            checkOutput("wdfEnd", bus.app_wdf_end, 1'b1);
            checkOutput("wdfMask", bus.app_wdf_mask, 16'h0000);
            haveData = 1'b1;
            pendData = bus.app_wdf_data;
        end
        if (haveCmd && haveData) begin
            if (expWr.size() != 0) begin
                e = expWr.pop_front();
                checkOutput("wrCmdAddr", pendAddr, lineAddr(e.addr));
                checkOutput("wrData", pendData, e.data);
            end else begin
                checkOutput("unexpectedWrite", 1'b1, 1'b0);
            end
            mem[pendAddr] = pendData;
            ddrWrites++;
            haveCmd  = 1'b0;
            haveData = 1'b0;
        end
        if (bus.rd_resp_fifo_wr_en) begin
            checkOutput("pushWhileFull", bus.rd_resp_fifo_full, 1'b0);
            if (expResp.size() != 0) checkOutput("pushData", bus.rd_resp_fifo_data, expResp.pop_front());
            else checkOutput("unexpectedPush", 1'b1, 1'b0);
            lastPush  = bus.rd_resp_fifo_data;
            pushCycle = cycle;
            pushes++;
        end
    endtask

    // Background environment: drive on the falling edge, observe 1 ns later.
    task automatic envLoop();
        forever begin
            @(negedge clk);
            applyStimulus();
            #1;
            observeCycle();
        end
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #2;
    endtask

    task automatic waitIdle(input string tag, input int budget);
        int n = 0;
        while ((busy || wrQ.size() != 0 || rdQ.size() != 0) && n < budget) begin
            nextCycle();
            n++;
        end
        checkOutput(tag, n < budget, 1'b1);
    endtask

    // Main test sequence.
    initial begin
        wrEntry_t w;
        logic [127:0] d;
        int p0;
        int n;
        int rN;

        reset = 1'b1;
        calib = 1'b0;
        applyStimulus();
        fork
            envLoop();
        join_none
        repeat (3) nextCycle();

        checkOutput("rstBusy", busy, 1'b0);
        checkOutput("rstStrobes", {bus.wr_fifo_rd_en, bus.rd_req_fifo_rd_en, bus.rd_resp_fifo_wr_en,
                                   bus.app_en, bus.app_wdf_wren, bus.app_wdf_end}, 6'b0);
        checkOutput("rstAppAddr", bus.app_addr, 28'h0);
        checkOutput("rstAppCmd", bus.app_cmd, 3'b000);
        checkOutput("rstWdfData", bus.app_wdf_data, 128'h0);
        checkOutput("rstRespData", bus.rd_resp_fifo_data, 128'h0);
        checkOutput("rstTimeoutErr", timeoutErr, 1'b0);
        reset = 1'b0;
        nextCycle();

        // Uncalibrated: no pops. Then priority: the write goes first and the read sees it.
        w.addr = 32'h0000_0100;
        w.data = randData();
        wrQ.push_back(w);
        rdQ.push_back(32'h0000_0100);
        repeat (20) nextCycle();
        checkOutput("uncalWrPops", wrPops, 0);
        checkOutput("uncalRdPops", rdPops, 0);
        checkOutput("uncalBusy", busy, 1'b0);
        calib = 1'b1;
        waitIdle("priorityDrain", 200);
        checkOutput("priorityWrites", ddrWrites, 1);
        checkOutput("priorityReads", ddrReads, 1);
        checkOutput("priorityRaw", lastPush, w.data);

        // Write path with app_rdy low for three cycles.
        rdyPct = 0;
        w.addr = 32'h0000_1234;
        w.data = 128'h0123_4567_89AB_CDEF_0123_4567_89AB_CDEF;
        p0 = wrPops;
        wrQ.push_back(w);
        n = 0;
        while (wrPops == p0 && n < 50) begin nextCycle(); n++; end
        checkOutput("wrPopOnce", wrPops, p0 + 1);
        checkOutput("wrAppAddr", bus.app_addr, 28'h000_1230);
        checkOutput("wrAppCmd", bus.app_cmd, 3'b000);
        checkOutput("wrWdfData", bus.app_wdf_data, w.data);
        checkOutput("wrWdfWren", bus.app_wdf_wren, 1'b1);
        for (int i = 0; i < 3; i++) begin
            checkOutput("wrHoldEn", bus.app_en, 1'b1);
            if (i < 2) nextCycle();
        end
        rdyPct = 100;
        waitIdle("wrDrain", 50);
        checkOutput("wrPopTotal", wrPops, p0 + 1);
        checkOutput("wrMem", memRead(28'h000_1230), w.data);

        // Read path with a fixed 10-cycle DDR latency.
        latFixed = 10;
        mem[28'h000_0040] = 128'hAAAA_AAAA_AAAA_AAAA_5555_5555_5555_5555;
        p0 = pushes;
        rdQ.push_back(32'h0000_0040);
        n = 0;
        while (pushes == p0 && n < 100) begin nextCycle(); n++; end
        checkOutput("rdPushOnce", pushes, p0 + 1);
        checkOutput("rdData", lastPush, 128'hAAAA_AAAA_AAAA_AAAA_5555_5555_5555_5555);
        checkOutput("rdLatency", pushCycle - rdAcceptCycle, 11);
        checkOutput("rdBusyAfter", busy, 1'b0);
        nextCycle();
        checkOutput("rdNoExtraPush", pushes, p0 + 1);

        // Backpressure: the read-out FIFO is full while the line waits.
        latFixed = 2;
        forceFull = 1'b1;
        d = randData();
        mem[28'h000_0080] = d;
        p0 = pushes;
        rdQ.push_back(32'h0000_0080);
        n = 0;
        while (bus.rd_resp_fifo_data !== d && n < 50) begin nextCycle(); n++; end
        checkOutput("bpReached", n < 50, 1'b1);
        for (int i = 0; i < 5; i++) begin
            checkOutput("bpNoPush", bus.rd_resp_fifo_wr_en, 1'b0);
            checkOutput("bpHold", bus.rd_resp_fifo_data, d);
            nextCycle();
        end
        checkOutput("bpPushCount", pushes, p0);
        forceFull = 1'b0;
        nextCycle();
        checkOutput("bpPushAfter", pushes, p0 + 1);
        checkOutput("bpData", lastPush, d);

        // Reset while waiting for read data; a late response must not be pushed.
        respEnable = 1'b0;
        p0 = ddrReads;
        rdQ.push_back(32'h0000_0040);
        n = 0;
        while (ddrReads == p0 && n < 50) begin nextCycle(); n++; end
        checkOutput("rstMidBusy", busy, 1'b1);
        reset = 1'b1;
        nextCycle();
        checkOutput("rstMidIdle", busy, 1'b0);
        checkOutput("rstMidStrobes", {bus.wr_fifo_rd_en, bus.rd_req_fifo_rd_en, bus.rd_resp_fifo_wr_en,
                                      bus.app_en, bus.app_wdf_wren}, 5'b0);
        reset = 1'b0;
        expWr.delete();
        expRd.delete();
        expResp.delete();
        haveCmd  = 1'b0;
        haveData = 1'b0;
        respCnt  = 0;
        p0 = pushes;
        injectValid = 1'b1;
        repeat (6) nextCycle();
        checkOutput("rstMidNoPush", pushes, p0);
        checkOutput("rstMidStillIdle", busy, 1'b0);

`ifdef DDR3_BRIDGE_TIMEOUT_EN
        // Watchdog: no read response at all.
        p0 = ddrReads;
        rN = pushes;
        rdQ.push_back(32'h0000_0200);
        n = 0;
        while (ddrReads == p0 && n < 50) begin nextCycle(); n++; end
        expResp.delete();
        expResp.push_back({4{32'hDEAD_BEEF}});
        n = 0;
        while (pushes == rN && n < 100) begin nextCycle(); n++; end
        checkOutput("tmoPush", pushes, rN + 1);
        checkOutput("tmoData", lastPush, {4{32'hDEAD_BEEF}});
        checkOutput("tmoLatency", pushCycle - rdAcceptCycle, TMO + 1);
        checkOutput("tmoErrSet", timeoutErr, 1'b1);
        repeat (10) nextCycle();
        checkOutput("tmoErrSticky", timeoutErr, 1'b1);
        reset = 1'b1;
        nextCycle();
        reset = 1'b0;
        nextCycle();
        checkOutput("tmoErrCleared", timeoutErr, 1'b0);
`else
        checkOutput("tmoErrTied", timeoutErr, 1'b0);
`endif
        respEnable = 1'b1;

        // Randomized traffic: mixed writes and reads to a few shared lines.
        latFixed = 0;
        rdyPct   = 60;
        wdfPct   = 60;
        fullPct  = 30;
        p0 = pushes;
        rN = 0;
        for (int i = 0; i < 150; i++) begin
            nextCycle();
            calib = ($urandom_range(9) != 0);
            if ($urandom_range(3) == 0) begin
                w.addr = {4'($urandom), 28'h000_1000 + 28'($urandom_range(7) << 4) + 28'($urandom_range(15))};
                w.data = randData();
                wrQ.push_back(w);
            end
            if ($urandom_range(3) == 0) begin
                rdQ.push_back({4'($urandom), 28'h000_1000 + 28'($urandom_range(7) << 4) + 28'($urandom_range(15))});
                rN++;
            end
        end
        calib = 1'b1;
        waitIdle("randDrain", 4000);
        checkOutput("randPushCount", pushes - p0, rN);
        checkOutput("randExpEmpty", expWr.size() + expRd.size() + expResp.size(), 0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
